// File: rtl/mem_seq_master.sv
`default_nettype none
//==============================================================================
// Module      : mem_seq_master
// Description : Write/read-back BIST initiator for a single-port memory. On an
//               accepted start it writes (seed + i) to (base_addr + i) for
//               i = 0..N-1, reads the same range back, and compares every
//               returned word against the regenerated pattern.
// Ports       : clk_i            - clock, rising edge
//               rst_ni           - synchronous active-low reset
//               start_i          - run request, honoured only in IDLE
//               num_ops_i        - word count N, captured on start
//               base_addr_i      - first address, captured on start
//               seed_i           - pattern seed, captured on start
//               en_o/wr_rd_o     - memory enable / 1=write 0=read
//               addr_o/wr_data_o - memory address / write data
//               rd_data_i        - memory read data, valid RD_LAT edges after
//                                  the read is sampled (RD_LAT legal 1..4)
//               busy_o/done_o    - run in progress / one-cycle end pulse
//               pass_o           - last run had no mismatches
//               err_count_o      - saturating mismatch count
//               first_err_addr_o - address of first mismatch, 0 if none
// Revision    : 1.0 - initial release
//==============================================================================
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module mem_seq_master #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int CNT_WIDTH  = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  num_ops_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  en_o,
    output logic                  wr_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [CNT_WIDTH-1:0]  err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] c_DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  en_q, en_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] pat_q, pat_d;      // pattern word of the op on the bus
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;      // index of the op on the bus
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [CNT_WIDTH-1:0]  err_q, err_d;
    logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;
    logic                  push;

    // Expected-word delay line: a read sampled at edge N enters stage 0 at
    // that edge and sits in stage RD_LAT-1 just before edge N+RD_LAT, which
    // is exactly when its data is on rd_data_i.
    logic [RD_LAT-1:0]     dl_vld_q;
    logic [DATA_WIDTH-1:0] dl_dat_q [RD_LAT];
    logic [ADDR_WIDTH-1:0] dl_adr_q [RD_LAT];

    logic w_last;
    assign w_last = (idx_q == (num_q - c_CNT_ONE));

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        wr_rd_d   = wr_rd_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        pat_d     = pat_q;
        idx_d     = idx_q;
        num_d     = num_q;
        base_d    = base_q;
        seed_d    = seed_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        ferr_d    = ferr_q;
        push      = 1'b0;

        // Retire the oldest outstanding read.
        if (dl_vld_q[RD_LAT-1] && (rd_data_i != dl_dat_q[RD_LAT-1])) begin
            if (err_q == '0) begin
                ferr_d = dl_adr_q[RD_LAT-1];
            end
            if (err_q != '1) begin
                err_d = err_q + c_CNT_ONE;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    num_d  = num_ops_i;
                    base_d = base_addr_i;
                    seed_d = seed_i;
                    err_d  = '0;
                    ferr_d = '0;
                    pass_d = 1'b0;
                    busy_d = 1'b1;
                    idx_d  = '0;
                    if (num_ops_i == '0) begin
                        // Empty run still spends one cycle before done.
                        state_d = S_DRAIN;
                    end else begin
                        state_d   = S_WRITE;
                        en_d      = 1'b1;
                        wr_rd_d   = 1'b1;
                        addr_d    = base_addr_i;
                        wr_data_d = seed_i;
                        pat_d     = seed_i;
                    end
                end
            end
            S_WRITE: begin
                if (w_last) begin
                    // Straight into reads, no idle cycle in between.
                    state_d = S_READ;
                    idx_d   = '0;
                    wr_rd_d = 1'b0;
                    addr_d  = base_q;
                    pat_d   = seed_q;
                end else begin
                    idx_d     = idx_q + c_CNT_ONE;
                    addr_d    = addr_q + c_ADDR_ONE;
                    pat_d     = pat_q + c_DATA_ONE;
                    wr_data_d = pat_q + c_DATA_ONE;
                end
            end
            S_READ: begin
                push = 1'b1;
                if (w_last) begin
                    state_d = S_DRAIN;
                    en_d    = 1'b0;
                end else begin
                    idx_d  = idx_q + c_CNT_ONE;
                    addr_d = addr_q + c_ADDR_ONE;
                    pat_d  = pat_q + c_DATA_ONE;
                end
            end
            S_DRAIN: begin
                if (dl_vld_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_d == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            wr_rd_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            pat_q     <= '0;
            idx_q     <= '0;
            num_q     <= '0;
            base_q    <= '0;
            seed_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ferr_q    <= '0;
            for (int j = 0; j < RD_LAT; j++) begin
                dl_vld_q[j] <= 1'b0;
                dl_dat_q[j] <= '0;
                dl_adr_q[j] <= '0;
            end
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            wr_rd_q   <= wr_rd_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            base_q    <= base_d;
            seed_q    <= seed_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            ferr_q    <= ferr_d;
            dl_vld_q[0] <= push;
            dl_dat_q[0] <= pat_q;
            dl_adr_q[0] <= addr_q;
            for (int j = 1; j < RD_LAT; j++) begin
                dl_vld_q[j] <= dl_vld_q[j-1];
                dl_dat_q[j] <= dl_dat_q[j-1];
                dl_adr_q[j] <= dl_adr_q[j-1];
            end
        end
    end

    assign en_o             = en_q;
    assign wr_rd_o          = wr_rd_q;
    assign addr_o           = addr_q;
    assign wr_data_o        = wr_data_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = ferr_q;

endmodule
`default_nettype wire
